// File: rtl/forwarding_unit.sv
// rtl/forwarding_unit.sv - EX-stage operand bypass select generation
//
// Picks where each ALU operand comes from, based on the newest in-flight
// producer of that source register.
//
// Parameters:
//   ADDR_W  register address width
//   REG_OUT 0 = combinational selects, 1 = selects registered on CLK
//
// Ports:
//   CLK              rising-edge clock (REG_OUT=1 only)
//   RST              synchronous active-high reset (REG_OUT=1 only)
//   ARD_EX_MEM       destination register held in EX/MEM
//   ARD_MEM_WB       destination register held in MEM/WB
//   ARS1, ARS2       source registers of the instruction in EX
//   REGWRITE_EX_MEM  EX/MEM instruction writes the register file
//   REGWRITE_MEM_WB  MEM/WB instruction writes the register file
//   FORWARD_A/B      operand selects: 00 regfile, 10 EX/MEM, 01 MEM/WB
module forwarding_unit #(
    parameter int ADDR_W  = 5,
    parameter bit REG_OUT = 1'b0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] ARD_EX_MEM,
    input  logic [ADDR_W-1:0] ARD_MEM_WB,
    input  logic [ADDR_W-1:0] ARS1,
    input  logic [ADDR_W-1:0] ARS2,
    input  logic              REGWRITE_EX_MEM,
    input  logic              REGWRITE_MEM_WB,
    output logic [1:0]        FORWARD_A,
    output logic [1:0]        FORWARD_B
);

    localparam logic [1:0] SEL_REGFILE = 2'b00;
    localparam logic [1:0] SEL_EX_MEM  = 2'b10;
    localparam logic [1:0] SEL_MEM_WB  = 2'b01;

    // x0 is hardwired to zero, so a "write" to it must never be bypassed.
    // EX/MEM is checked first because it carries the younger result.
    function automatic logic [1:0] select_for(
        input logic [ADDR_W-1:0] rs,
        input logic [ADDR_W-1:0] rd_em,
        input logic              we_em,
        input logic [ADDR_W-1:0] rd_mw,
        input logic              we_mw
    );
        logic [1:0] sel;
        sel = SEL_REGFILE;
        if (we_em && (rd_em != '0) && (rd_em == rs)) begin
            sel = SEL_EX_MEM;
        end else if (we_mw && (rd_mw != '0) && (rd_mw == rs)) begin
            sel = SEL_MEM_WB;
        end
        return sel;
    endfunction

    logic [1:0] fwd_a_comb;
    logic [1:0] fwd_b_comb;

    always_comb begin
        fwd_a_comb = select_for(ARS1, ARD_EX_MEM, REGWRITE_EX_MEM,
                                ARD_MEM_WB, REGWRITE_MEM_WB);
        fwd_b_comb = select_for(ARS2, ARD_EX_MEM, REGWRITE_EX_MEM,
                                ARD_MEM_WB, REGWRITE_MEM_WB);
    end

    generate
        if (REG_OUT) begin : g_reg
            logic [1:0] fwd_a_q;
            logic [1:0] fwd_b_q;

            always_ff @(posedge CLK) begin
                if (RST) begin
                    fwd_a_q <= SEL_REGFILE;
                    fwd_b_q <= SEL_REGFILE;
                end else begin
                    fwd_a_q <= fwd_a_comb;
                    fwd_b_q <= fwd_b_comb;
                end
            end

            assign FORWARD_A = fwd_a_q;
            assign FORWARD_B = fwd_b_q;
        end else begin : g_comb
            // Clock and reset have no function in the combinational build.
            logic unused_clk_rst;
            assign unused_clk_rst = CLK ^ RST;

            assign FORWARD_A = fwd_a_comb;
            assign FORWARD_B = fwd_b_comb;
        end
    endgenerate

endmodule

// File: tb/tb_forwarding_unit.sv
// tb/tb_forwarding_unit.sv - bench for forwarding_unit, combinational and registered builds
module tb_forwarding_unit;

    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] rd_em, rd_mw, rs1, rs2;
    logic          we_em, we_mw;
    logic [1:0]    c_fa, c_fb, r_fa, r_fb;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    forwarding_unit #(.ADDR_W(AW), .REG_OUT(1'b0)) u_comb (
        .CLK(clk), .RST(rst),
        .ARD_EX_MEM(rd_em), .ARD_MEM_WB(rd_mw), .ARS1(rs1), .ARS2(rs2),
        .REGWRITE_EX_MEM(we_em), .REGWRITE_MEM_WB(we_mw),
        .FORWARD_A(c_fa), .FORWARD_B(c_fb)
    );

    forwarding_unit #(.ADDR_W(AW), .REG_OUT(1'b1)) u_reg (
        .CLK(clk), .RST(rst),
        .ARD_EX_MEM(rd_em), .ARD_MEM_WB(rd_mw), .ARS1(rs1), .ARS2(rs2),
        .REGWRITE_EX_MEM(we_em), .REGWRITE_MEM_WB(we_mw),
        .FORWARD_A(r_fa), .FORWARD_B(r_fb)
    );

    // Reference: list the in-flight writers newest first, skipping those that
    // do not write or target x0, and take the first one producing rs.
    typedef struct {
        int         rd;
        logic [1:0] code;
    } producer_t;

    function automatic logic [1:0] ref_sel(input int rs);
        producer_t q[$];
        if (we_em && rd_em != 0) q.push_back('{int'(rd_em), 2'b10});
        if (we_mw && rd_mw != 0) q.push_back('{int'(rd_mw), 2'b01});
        foreach (q[i]) begin
            if (q[i].rd == rs) return q[i].code;
        end
        return 2'b00;
    endfunction

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive one vector mid-cycle, check the combinational build immediately
    // and the registered build after the following rising edge.
    task automatic step(input string tag, input int a_em, input int a_mw,
                        input int a1, input int a2, input bit w_em, input bit w_mw);
        logic [1:0] ea, eb;
        @(negedge clk);
        rd_em = a_em[AW-1:0]; rd_mw = a_mw[AW-1:0];
        rs1 = a1[AW-1:0];     rs2 = a2[AW-1:0];
        we_em = w_em;         we_mw = w_mw;
        ea = ref_sel(a1);
        eb = ref_sel(a2);
        #1;
        check({tag, " comb A"}, c_fa, ea);
        check({tag, " comb B"}, c_fb, eb);
        @(posedge clk); #1;
        check({tag, " reg A"}, r_fa, ea);
        check({tag, " reg B"}, r_fb, eb);
    endtask

    task automatic expect_pair(input string tag, input logic [1:0] ea, input logic [1:0] eb);
        check({tag, " A"}, c_fa, ea);
        check({tag, " B"}, c_fb, eb);
    endtask

    initial begin
        rd_em = '0; rd_mw = '0; rs1 = '0; rs2 = '0; we_em = 1'b0; we_mw = 1'b0;

        // Registered build: reset for two edges.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset A", r_fa, 2'b00);
        check("reset B", r_fb, 2'b00);

        // Latency: EX/MEM hazard on rs1 appears one edge after it is applied.
        @(negedge clk);
        rst = 1'b0;
        rd_em = 5'd3; rd_mw = 5'd0; rs1 = 5'd3; rs2 = 5'd5; we_em = 1'b1; we_mw = 1'b0;
        #1;
        check("latency pre-edge A", r_fa, 2'b00);
        @(posedge clk); #1;
        check("latency post-edge A", r_fa, 2'b10);
        check("latency post-edge B", r_fb, 2'b00);

        // Reset asserted while the hazard is still applied.
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid reset A", r_fa, 2'b00);
        check("mid reset B", r_fb, 2'b00);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors, with literal expectations for the combinational build.
        step("nomatch we0", 1, 2, 3, 4, 0, 0);  expect_pair("nomatch we0 lit", 2'b00, 2'b00);
        step("nomatch we1", 1, 2, 3, 4, 1, 1);  expect_pair("nomatch we1 lit", 2'b00, 2'b00);
        step("exmem rs1",   3, 0, 3, 5, 1, 0);  expect_pair("exmem rs1 lit", 2'b10, 2'b00);
        step("exmem rs1 off", 3, 0, 3, 5, 0, 0); expect_pair("exmem rs1 off lit", 2'b00, 2'b00);
        step("exmem rs2",   5, 0, 3, 5, 1, 0);  expect_pair("exmem rs2 lit", 2'b00, 2'b10);
        step("exmem rs2 off", 5, 0, 3, 5, 0, 0); expect_pair("exmem rs2 off lit", 2'b00, 2'b00);
        step("memwb rs1",   0, 7, 7, 4, 0, 1);  expect_pair("memwb rs1 lit", 2'b01, 2'b00);
        step("memwb rs1 off", 0, 7, 7, 4, 0, 0); expect_pair("memwb rs1 off lit", 2'b00, 2'b00);
        step("memwb rs2",   0, 8, 3, 8, 0, 1);  expect_pair("memwb rs2 lit", 2'b00, 2'b01);
        step("memwb rs2 off", 0, 8, 3, 8, 0, 0); expect_pair("memwb rs2 off lit", 2'b00, 2'b00);
        step("double",      9, 10, 9, 10, 1, 1); expect_pair("double lit", 2'b10, 2'b01);
        step("double off",  9, 10, 9, 10, 0, 0); expect_pair("double off lit", 2'b00, 2'b00);
        step("priority",    6, 6, 6, 6, 1, 1);   expect_pair("priority lit", 2'b10, 2'b10);
        step("x0",          0, 0, 0, 0, 1, 1);   expect_pair("x0 lit", 2'b00, 2'b00);
        step("x0 exmem only", 0, 4, 0, 4, 1, 1); expect_pair("x0 exmem only lit", 2'b00, 2'b01);

        // Random vectors; addresses drawn from a small pool so matches are common.
        for (int i = 0; i < 300; i++) begin
            int pool;
            pool = (i % 2 == 0) ? 3 : 31;
            step("random",
                 $urandom_range(pool, 0), $urandom_range(pool, 0),
                 $urandom_range(pool, 0), $urandom_range(pool, 0),
                 1'($urandom), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/forwarding_unit.md
Name: forwarding_unit

Overview:
- Data-forwarding (bypass) control for the 5-stage pipelined RISC-V core, located at the EX stage.
- Compares the EX-stage source register addresses (rs1, rs2) against the destination addresses held in the EX/MEM and MEM/WB pipeline registers.
- Produces 2-bit mux selects for the two ALU operand forwarding muxes.
- Default build is purely combinational. An optional registered-output mode uses the clock and reset.

Parameters:
- ADDR_W, 5, register address width (32 architectural registers).
- REG_OUT, 0, 0 = combinational selects; 1 = selects registered on CLK (one-cycle latency).

Ports:
- CLK  input  1  system clock, rising edge; used only when REG_OUT=1.
- RST  input  1  synchronous, active-high reset; used only when REG_OUT=1.
- ARD_EX_MEM  input  ADDR_W  destination register address in EX/MEM.
- ARD_MEM_WB  input  ADDR_W  destination register address in MEM/WB.
- ARS1  input  ADDR_W  source register 1 address of the instruction in EX.
- ARS2  input  ADDR_W  source register 2 address of the instruction in EX.
- REGWRITE_EX_MEM  input  1  EX/MEM instruction writes the register file.
- REGWRITE_MEM_WB  input  1  MEM/WB instruction writes the register file.
- FORWARD_A  output  2  operand A select.
- FORWARD_B  output  2  operand B select.

Behaviour:
- Select encoding, identical for A and B:
  - 00 = register-file value (no forwarding).
  - 10 = forward the EX/MEM ALU result.
  - 01 = forward the MEM/WB write-back value.
  - 11 is never produced.
- FORWARD_A, evaluated in priority order:
  - If REGWRITE_EX_MEM=1, ARD_EX_MEM!=0 and ARD_EX_MEM==ARS1, then 10.
  - Else if REGWRITE_MEM_WB=1, ARD_MEM_WB!=0 and ARD_MEM_WB==ARS1, then 01.
  - Else 00.
- FORWARD_B: same rule set applied to ARS2.
- Priority: when both stages match the same source, EX/MEM wins (it holds the newer value), giving 10.
- A and B are evaluated independently. Both may forward in the same cycle, from the same stage or from different stages.
- Register x0 (address 0) is never forwarded, even with the write enable set; the result is 00.
- A write enable of 0 suppresses that stage's match completely, regardless of address equality.
- REG_OUT=0:
  - Outputs are a pure function of the current inputs and settle within the same delta/cycle.
  - CLK and RST are ignored; there is no internal state.
- REG_OUT=1:
  - Outputs are registered on the rising edge of CLK, giving one-cycle latency.
  - RST high at a rising edge forces both outputs to 00. Reset has priority over input evaluation.
  - After reset deasserts, the first edge captures the selects computed from the current inputs.
  - Reset asserted mid-operation clears the outputs at the next edge.
- No X propagation: every input combination yields a defined 00, 01 or 10.

Test Plan:
- No match (EX/MEM=1, MEM/WB=2, rs1=3, rs2=4, both write enables 0) -> A=00, B=00. Same addresses with both enables 1 -> A=00, B=00.
- EX/MEM hazard on rs1 (EX/MEM=3, rs1=3, rs2=5, weEXMEM=1) -> A=10, B=00. Same with weEXMEM=0 -> A=00, B=00. Repeat with EX/MEM=5 matching rs2 -> A=00, B=10, then 00/00.
- MEM/WB hazard (MEM/WB=7, rs1=7, weMEMWB=1) -> A=01, B=00. With MEM/WB=8, rs2=8 -> A=00, B=01. Each with the enable cleared -> 00/00.
- Double forwarding (EX/MEM=9=rs1, MEM/WB=10=rs2, both enables 1) -> A=10, B=01. Both enables 0 -> 00/00.
- Priority and x0:
  - EX/MEM=MEM/WB=6=rs1=rs2, both enables 1 -> A=10, B=10.
  - All addresses 0, enables 1 -> A=00, B=00.
- REG_OUT=1 build:
  - RST high for 2 edges -> outputs 00.
  - Apply the rs1 EX/MEM hazard -> A=10 appears one edge later.
  - Assert RST while the hazard is still applied -> A returns to 00 at the next edge.
